// File: rtl/board_reader.sv
// board_reader: walks every ram_board cell in raster order, streams each cell with its
// macro-board state over valid/ready, and tallies the pieces of each player.
module board_reader #(
    parameter logic [3:0] ADDR_FIRST = 4'd1,
    parameter logic [3:0] ADDR_LAST  = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] rd_addr_macro,
    output logic [3:0] rd_addr_micro,
    input  logic [1:0] rd_q,
    input  logic [1:0] rd_state,
    output logic       cell_valid,
    input  logic       cell_ready,
    output logic [3:0] cell_macro,
    output logic [3:0] cell_micro,
    output logic [1:0] cell_data,
    output logic [1:0] cell_state,
    output logic       busy,
    output logic       done,
    output logic [6:0] p1_count,
    output logic [6:0] p2_count,
    output logic       bad_seen
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, DONE} state_t;
    state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_addr_macro <= '0;
            rd_addr_micro <= '0;
            cell_valid    <= 1'b0;
            cell_macro    <= '0;
            cell_micro    <= '0;
            cell_data     <= '0;
            cell_state    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            p1_count      <= '0;
            p2_count      <= '0;
            bad_seen      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rd_addr_macro <= ADDR_FIRST;
                    rd_addr_micro <= ADDR_FIRST;
                    p1_count      <= '0;
                    p2_count      <= '0;
                    bad_seen      <= 1'b0;
                    busy          <= 1'b1;
                    state         <= FETCH;
                end
                FETCH: state <= CAPTURE;
                // RAM data for the address driven in FETCH is valid now
                CAPTURE: begin
                    cell_data  <= rd_q;
                    cell_state <= rd_state;
                    cell_macro <= rd_addr_macro;
                    cell_micro <= rd_addr_micro;
                    p1_count   <= p1_count + 7'(rd_q == 2'b01);
                    p2_count   <= p2_count + 7'(rd_q == 2'b10);
                    bad_seen   <= bad_seen | (rd_q == 2'b11);
                    cell_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: if (cell_ready) begin
                    cell_valid <= 1'b0;
                    if (rd_addr_macro == ADDR_LAST && rd_addr_micro == ADDR_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rd_addr_micro <= (rd_addr_micro == ADDR_LAST) ? ADDR_FIRST : rd_addr_micro + 4'd1;
                        rd_addr_macro <= (rd_addr_micro == ADDR_LAST) ? rd_addr_macro + 4'd1 : rd_addr_macro;
                        state         <= FETCH;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_reader.sv
// tb_board_reader: directed scans of board_reader against a 1-cycle-latency RAM model.
module tb_board_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cell_ready = 1'b1;
    logic [3:0] rd_addr_macro, rd_addr_micro, cell_macro, cell_micro;
    logic [1:0] rd_q, rd_state, cell_data, cell_state;
    logic cell_valid, busy, done, bad_seen;
    logic [6:0] p1_count, p2_count;
    logic [1:0] mem [0:15][0:15];
    logic [1:0] st [0:15];
    int checks = 0;
    int failures = 0;
    int nrec, ndone, dur, cnt;

    board_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_addr_macro(rd_addr_macro), .rd_addr_micro(rd_addr_micro),
        .rd_q(rd_q), .rd_state(rd_state),
        .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_macro(cell_macro), .cell_micro(cell_micro),
        .cell_data(cell_data), .cell_state(cell_state),
        .busy(busy), .done(done),
        .p1_count(p1_count), .p2_count(p2_count), .bad_seen(bad_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_q     <= mem[rd_addr_macro][rd_addr_micro];
        rd_state <= st[rd_addr_macro];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {26'd0, rd_addr_macro, rd_addr_micro, cell_valid, cell_macro, cell_micro,
                cell_data, cell_state, busy, done, p1_count, p2_count, bad_seen};
    endfunction

    // Starts a scan and follows it to done; optional stall and re-start at given record indices.
    task automatic scan(input int stall_rec, input int restart_rec,
                        output int nr, output int nd, output int dr);
        logic [3:0] em = 4'd1, eu = 4'd1;
        logic [19:0] held = '0;
        int left = 5;
        int cyc = 1;
        nr = 0; nd = 0; dr = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise_counters_clear", {busy, p1_count, p2_count, bad_seen}, {1'b1, 15'd0});
        while (cyc < 600 && nd == 0) begin
            start = 1'b0;
            if (done) begin nd++; dr = cyc; end
            if (cell_valid && nr == stall_rec && left > 0) begin
                if (left < 5)
                    chk("stall_hold", {cell_valid, cell_macro, cell_micro, cell_data, cell_state,
                                       rd_addr_macro, rd_addr_micro}, {1'b1, held});
                held = {cell_macro, cell_micro, cell_data, cell_state, rd_addr_macro, rd_addr_micro};
                cell_ready = 1'b0;
                left--;
            end else if (cell_valid) begin
                cell_ready = 1'b1;
                chk("record", {cell_macro, cell_micro, cell_data, cell_state},
                    {em, eu, mem[em][eu], st[em]});
                nr++;
                if (nr == restart_rec) start = 1'b1;
                if (eu == 4'd9) begin eu = 4'd1; em++; end else eu++;
            end
            @(negedge clk);
            cyc++;
        end
        if (nd == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) begin
            if (done) nd++;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            st[i] = 2'b00;
            for (int j = 0; j < 16; j++) mem[i][j] = 2'b00;
        end
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, cell_valid, done}, 3'b000);

        scan(-1, -1, nrec, ndone, dur);
        chk("empty_nrec", nrec, 81);
        chk("empty_ndone", ndone, 1);
        chk("empty_done_cycle", dur, 244);
        chk("empty_counts", {p1_count, p2_count, bad_seen}, 15'd0);

        mem[2][1] = 2'b01; mem[2][2] = 2'b01; mem[2][3] = 2'b01; st[2] = 2'b01;
        scan(-1, -1, nrec, ndone, dur);
        chk("p1_nrec", nrec, 81);
        chk("p1_counts", {p1_count, p2_count, bad_seen}, {7'd3, 7'd0, 1'b0});

        scan(40, -1, nrec, ndone, dur);
        chk("stall_nrec", nrec, 81);
        chk("stall_done_cycle", dur, 249);
        chk("stall_counts", {p1_count, p2_count}, {7'd3, 7'd0});

        mem[9][9] = 2'b11; mem[1][1] = 2'b10;
        scan(-1, -1, nrec, ndone, dur);
        chk("bad_counts", {p1_count, p2_count, bad_seen}, {7'd3, 7'd1, 1'b1});
        chk("bad_hold_after_done", {busy, bad_seen, p2_count}, {1'b0, 1'b1, 7'd1});

        mem[9][9] = 2'b00; mem[1][1] = 2'b00;
        scan(-1, 40, nrec, ndone, dur);
        chk("restart_nrec", nrec, 81);
        chk("restart_ndone", ndone, 1);
        chk("recount", {p1_count, p2_count, bad_seen}, {7'd3, 7'd0, 1'b0});

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 30; i++) begin
            if (cell_valid) cnt++;
            @(negedge clk);
        end
        chk("midscan_busy", {busy, 7'(cnt)}, {1'b1, 7'd30});
        rst_n = 1'b0;
        @(negedge clk);
        chk("midscan_reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midscan_idle", outs(), 64'd0);
        scan(-1, -1, nrec, ndone, dur);
        chk("after_reset_nrec", nrec, 81);
        chk("after_reset_done_cycle", dur, 244);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
